// File: rtl/mvu_pkg.sv
// Shared types and helpers for the MVU stream sequencer.
// The sequencer FSM state type lives here together with the address-width
// helper that the top level and the credit counter both size their
// counters with.
package mvu_pkg;

   // FILL streams a fresh vector in (nf == 0), REUSE replays it from the buffer.
   typedef enum logic {
      FILL  = 1'b0,
      REUSE = 1'b1
   } mvu_seq_state_t;

   // Bits needed to hold values 0..value-1, never less than one bit.
   function automatic int clog2_min1(input int value);
      int width;
      width = 0;
      while ((1 << width) < value) begin
         width = width + 1;
      end
      clog2_min1 = (width < 1) ? 1 : width;
   endfunction

endpackage

// File: rtl/mvu_credit_counter.sv
// Output-FIFO credit tracker for the MVU stream sequencer.
// Starts full at CREDITS, drops by one when a row is started and rises by one
// per downstream release. A release that arrives while already full is
// dropped and latches err_credit until reset.
module mvu_credit_counter
   import mvu_pkg::*;
#(
   parameter int CREDITS = 2
)(
   input  logic clock,
   input  logic resetn,
   input  logic consume,
   input  logic release_pulse,
   output logic has_credit,
   output logic err_credit
);

   localparam int CREDIT_BW = clog2_min1(CREDITS + 1);
   localparam logic [CREDIT_BW-1:0] CREDIT_MAX = CREDIT_BW'(CREDITS);

   logic [CREDIT_BW-1:0] credit;
   logic                 full;
   logic                 release_ok;

   assign full       = (credit == CREDIT_MAX);
   assign release_ok = release_pulse && !full;
   assign has_credit = (credit != '0);

   // Credit count: a consume and an accepted release in the same cycle cancel out.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         credit <= CREDIT_MAX;
      end else begin
         case ({consume, release_ok})
            2'b10:   credit <= credit - CREDIT_BW'(1);
            2'b01:   credit <= credit + CREDIT_BW'(1);
            default: credit <= credit;
         endcase
      end
   end

   // Sticky overflow flag for a release seen while every credit is already home.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         err_credit <= 1'b0;
      end else if (release_pulse && full) begin
         err_credit <= 1'b1;
      end
   end

endmodule

// File: rtl/mvu_stream_sequencer.sv
// MVU fold-schedule sequencer.
// Streams SF words per activation vector into the reuse buffer (FILL), then
// replays them for the remaining NF-1 neuron folds (REUSE), issuing one MVU
// operation per cycle with weight address and accumulator first/last flags.
// Row starts (sf == 0) are gated by output-FIFO credits.
// Optional feature macro: MVU_SEQ_PERF_EN enables the saturating
// perf_issue_cnt / perf_stall_cnt counters; otherwise those ports read 0.
module mvu_stream_sequencer
   import mvu_pkg::*;
#(
   parameter int SF           = 8,
   parameter int NF           = 8,
   parameter int CREDITS      = 2,
   parameter int WMEM_ADDR_BW = clog2_min1(SF * NF),
   parameter int IBUF_ADDR_BW = clog2_min1(SF)
)(
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    ibuf_we,
   output logic [IBUF_ADDR_BW-1:0] ibuf_waddr,
   output logic                    ibuf_re,
   output logic [IBUF_ADDR_BW-1:0] ibuf_raddr,
   output logic                    op_valid,
   output logic                    op_src_buf,
   output logic                    op_first,
   output logic                    op_last,
   output logic                    op_vec_last,
   output logic [WMEM_ADDR_BW-1:0] wmem_addr,
   input  logic                    out_release,
   output logic                    err_credit,
   output logic [31:0]             perf_issue_cnt,
   output logic [31:0]             perf_stall_cnt
);

   localparam int NF_BW = clog2_min1(NF);

   mvu_seq_state_t state;
   mvu_seq_state_t next_state;

   logic [IBUF_ADDR_BW-1:0] sf;
   logic [NF_BW-1:0]        nf;
   logic [WMEM_ADDR_BW-1:0] waddr;

   logic sf_first;
   logic sf_last;
   logic nf_last;
   logic waddr_last;
   logic has_credit;
   logic gate_ok;
   logic issue;
   logic consume;

   assign sf_first   = (sf == '0);
   assign sf_last    = (sf == IBUF_ADDR_BW'(SF - 1));
   assign nf_last    = (nf == NF_BW'(NF - 1));
   assign waddr_last = (waddr == WMEM_ADDR_BW'(SF * NF - 1));

   // Mid-row ops never wait; only starting a new row needs a free output slot.
   assign gate_ok = !sf_first || has_credit;
   assign consume = issue && sf_first;

   mvu_credit_counter #(
      .CREDITS(CREDITS)
   ) u_credit (
      .clock        (clock),
      .resetn       (resetn),
      .consume      (consume),
      .release_pulse(out_release),
      .has_credit   (has_credit),
      .err_credit   (err_credit)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state <= FILL;
      end else begin
         state <= next_state;
      end
   end

   // Leave FILL after the last streamed word of a multi-fold vector; return after the final replay row.
   always_comb begin
      next_state = state;
      if (issue && sf_last) begin
         case (state)
            FILL:    if (NF > 1) next_state = REUSE;
            REUSE:   if (nf_last) next_state = FILL;
            default: next_state = FILL;
         endcase
      end
   end

   // Issue decision and buffer port drive, combinational so read data lines up with op_valid.
   always_comb begin
      in_ready   = 1'b0;
      issue      = 1'b0;
      ibuf_we    = 1'b0;
      ibuf_waddr = '0;
      ibuf_re    = 1'b0;
      ibuf_raddr = '0;
      if (resetn) begin
         case (state)
            FILL: begin
               in_ready = gate_ok;
               issue    = in_valid && gate_ok;
               ibuf_we  = in_valid && gate_ok;
               if (in_valid && gate_ok) ibuf_waddr = sf;
            end
            REUSE: begin
               issue   = gate_ok;
               ibuf_re = gate_ok;
               if (gate_ok) ibuf_raddr = sf;
            end
            default: begin
               issue = 1'b0;
            end
         endcase
      end
   end

   // Fold counters and weight address advance once per issued op.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         sf    <= '0;
         nf    <= '0;
         waddr <= '0;
      end else if (issue) begin
         if (sf_last) begin
            sf <= '0;
            nf <= nf_last ? '0 : nf + NF_BW'(1);
         end else begin
            sf <= sf + IBUF_ADDR_BW'(1);
         end
         waddr <= waddr_last ? '0 : waddr + WMEM_ADDR_BW'(1);
      end
   end

   // Registered op descriptor presented the cycle after the issue decision.
   always_ff @(posedge clock) begin
      if (!resetn || !issue) begin
         op_valid    <= 1'b0;
         op_src_buf  <= 1'b0;
         op_first    <= 1'b0;
         op_last     <= 1'b0;
         op_vec_last <= 1'b0;
         wmem_addr   <= '0;
      end else begin
         op_valid    <= 1'b1;
         op_src_buf  <= (state == REUSE);
         op_first    <= sf_first;
         op_last     <= sf_last;
         op_vec_last <= sf_last && nf_last;
         wmem_addr   <= waddr;
      end
   end

`ifdef MVU_SEQ_PERF_EN
   logic stall;

   // A row start that would otherwise go ahead but has no output slot.
   assign stall = resetn && sf_first && !has_credit && ((state == FILL) ? in_valid : 1'b1);

   // Saturating issue counter.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         perf_issue_cnt <= '0;
      end else if (issue && (perf_issue_cnt != 32'hFFFF_FFFF)) begin
         perf_issue_cnt <= perf_issue_cnt + 32'd1;
      end
   end

   // Saturating credit-stall counter.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         perf_stall_cnt <= '0;
      end else if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
         perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`else
   assign perf_issue_cnt = '0;
   assign perf_stall_cnt = '0;
`endif

endmodule
